oai_reg_toggle: RTL and testbench
=================================

OAI_REG_TOGGLE -- requirements
Module: oai_reg_toggle

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of independent bit-slices.
REQ-002 SHALL have parameter NPAIR, default 2, number of OR-pairs ANDed per slice; legal range 1..8.
REQ-003 SHALL have parameter PIPE, default 1, number of output register stages; legal range 1..2.
REQ-004 SHALL have parameter CNTW, default 16, toggle-counter width; legal range 2..32.
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port EN  input  1  pipeline advance enable; low = stall.
REQ-008 SHALL have port INA  input  NPAIR*WIDTH  first OR leg; pair k, slice i at bit k*WIDTH+i.
REQ-009 SHALL have port INB  input  NPAIR*WIDTH  second OR leg; same bit layout as INA.
REQ-010 SHALL have port INC  input  WIDTH  per-slice AND term.
REQ-011 SHALL have port CLR  input  1  synchronous clear of TOGCNT and TOGSAT.
REQ-012 SHALL have port QN  output  WIDTH  registered OAI result.
REQ-013 SHALL have port QVLD  output  1  QN holds a computed (non-reset) result.
REQ-014 SHALL have port TOGCNT  output  CNTW  saturating count of QN bit toggles.
REQ-015 SHALL have port TOGSAT  output  1  sticky flag, TOGCNT has saturated.

Function
REQ-016 SHALL compute per slice f[i] = NOT( INC[i] AND (AND over k of (INA[k*WIDTH+i] OR INB[k*WIDTH+i])) ).
REQ-017 SHALL present f on QN exactly PIPE rising edges with EN=1 after inputs are sampled.
REQ-018 SHALL, with EN=0, hold all pipeline stages, QN, QVLD and TOGCNT unchanged; CLR still acts.
REQ-019 SHALL carry a valid bit alongside each stage; QVLD = valid bit of the last stage; a stage's valid bit sets when it loads with EN=1 and never clears except by RST.
REQ-020 SHALL, on each edge where the last stage loads, add popcount(new QN XOR old QN) to TOGCNT.
REQ-021 SHALL saturate TOGCNT at 2^CNTW-1 without wrap; TOGSAT sets on the edge the sum would reach or exceed 2^CNTW-1 and stays set.
REQ-022 SHALL give CLR priority over a same-cycle increment: TOGCNT=0, TOGSAT=0 after that edge, that cycle's toggles discarded.
REQ-023 SHALL count toggles regardless of QVLD, including the first transition out of reset value.
REQ-024 SHALL contain no combinational path from any input to any output.

Reset
REQ-025 SHALL, on an edge with RST=1, set every stage to all-ones, QN=all-ones, all valid bits=0, QVLD=0, TOGCNT=0, TOGSAT=0.
REQ-026 SHALL give RST priority over EN and CLR, including mid-pipeline; in-flight data discarded.
REQ-027 SHALL not count the QN change caused by reset.

Verification (WIDTH=4, NPAIR=2, PIPE=1, CNTW=16 unless noted)
REQ-028 SHALL cover reset: RST=1 two cycles, random inputs -> QN=4'hF, QVLD=0, TOGCNT=0, TOGSAT=0.
REQ-029 SHALL cover basic function: INA=8'h00, INB=8'hFF, INC=4'hA, EN=1 one edge -> QN=4'h5, QVLD=1, TOGCNT=2.
REQ-030 SHALL cover stall: after REQ-029, EN=0, INC=4'hF for 3 edges -> QN=4'h5, TOGCNT=2; EN=1 next edge -> QN=4'h0, TOGCNT=4.
REQ-031 SHALL cover saturation (CNTW=4): INA=INB=8'hFF, INC alternating 4'hF/4'h0 each edge, EN=1 -> TOGCNT 4,8,12,15, TOGSAT=1 on 4th toggle edge, TOGCNT stays 15 thereafter.
REQ-032 SHALL cover CLR collision: CLR=1 on an edge where QN toggles 4 bits -> TOGCNT=0, TOGSAT=0; next toggle edge -> TOGCNT=4.
REQ-033 SHALL cover reset mid-operation (PIPE=2): load QN=4'h5 path, assert RST while stage 1 holds new data -> QN=4'hF, QVLD=0; after release, QVLD=1 only after 2 EN=1 edges.

Source files
------------

// File: rtl/oai_reg_toggle.sv
// oai_reg_toggle: per-slice OR-AND-INVERT with an enable-gated output pipeline,
// a sticky valid bit per stage and a saturating count of output bit toggles.
module oai_reg_toggle #(
    parameter int WIDTH = 4,
    parameter int NPAIR = 2,
    parameter int PIPE  = 1,
    parameter int CNTW  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic [NPAIR*WIDTH-1:0] INA,
    input  logic [NPAIR*WIDTH-1:0] INB,
    input  logic [WIDTH-1:0]       INC,
    input  logic                   CLR,
    output logic [WIDTH-1:0]       QN,
    output logic                   QVLD,
    output logic [CNTW-1:0]        TOGCNT,
    output logic                   TOGSAT
);

    // Popcount width, and a sum width wide enough that cnt + popcount never wraps.
    localparam int PCW = $clog2(WIDTH + 1);
    localparam int SW  = ((CNTW > PCW) ? CNTW : PCW) + 1;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] oai_comb;

    // One OAI gate per slice: every pair ORed, the ORs ANDed with INC, then inverted.
    genvar gi, gk;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slice
            logic [NPAIR-1:0] pair_or;
            for (gk = 0; gk < NPAIR; gk++) begin : g_pair
                assign pair_or[gk] = INA[gk*WIDTH+gi] | INB[gk*WIDTH+gi];
            end
            assign oai_comb[gi] = ~(INC[gi] & (&pair_or));
        end
    endgenerate

    logic [WIDTH-1:0] stage_reg [PIPE];
    logic [WIDTH-1:0] stage_in  [PIPE];
    logic [PIPE-1:0]  valid_reg;
    logic [PIPE-1:0]  valid_in;

    // Output pipeline: stage 0 takes the gate result, later stages shift. The valid
    // bit travels with the data so QVLD only rises once real data reaches the end.
    generate
        for (gi = 0; gi < PIPE; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_in[gi] = oai_comb;
                assign valid_in[gi] = 1'b1;
            end else begin : g_next
                assign stage_in[gi] = stage_reg[gi-1];
                assign valid_in[gi] = valid_reg[gi-1];
            end

            // Stage register: reset to all-ones/invalid, load only when EN is high.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    stage_reg[gi] <= '1;
                    valid_reg[gi] <= 1'b0;
                end else if (EN) begin
                    stage_reg[gi] <= stage_in[gi];
                    valid_reg[gi] <= valid_in[gi];
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] toggle_bits;
    logic [PCW-1:0]   toggle_pop;
    logic [SW-1:0]    cnt_sum;
    logic             sat_hit;
    logic [CNTW-1:0]  cnt_reg;
    logic             sat_reg;

    assign toggle_bits = stage_in[PIPE-1] ^ stage_reg[PIPE-1];

    // Number of QN bits that flip if the last stage loads this cycle.
    always_comb begin
        toggle_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle_pop = toggle_pop + PCW'(toggle_bits[i]);
        end
    end

    assign cnt_sum = SW'(cnt_reg) + SW'(toggle_pop);
    assign sat_hit = (cnt_sum >= SW'(CNT_MAX));

    // Toggle counter: reset beats clear, clear beats the increment, and the
    // counter pins at its maximum once reached, raising the sticky flag.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            cnt_reg <= '0;
            sat_reg <= 1'b0;
        end else if (EN) begin
            if (sat_hit) begin
                cnt_reg <= CNT_MAX;
                sat_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_sum[CNTW-1:0];
            end
        end
    end

    assign QN     = stage_reg[PIPE-1];
    assign QVLD   = valid_reg[PIPE-1];
    assign TOGCNT = cnt_reg;
    assign TOGSAT = sat_reg;

endmodule

// File: tb/tb_oai_reg_toggle.sv
// Testbench for oai_reg_toggle: three instances (default, 4-bit counter, two-stage
// pipe) share the stimulus; each scenario checks the instance it targets through a
// scoreboard queue of expected outputs.
module tb_oai_reg_toggle;

    typedef struct packed {
        logic [3:0]  qn;
        logic        qvld;
        logic [15:0] cnt;
        logic        sat;
    } obs_t;

    logic       CLK = 1'b0;
    logic       RST, EN, CLR;
    logic [7:0] INA, INB;
    logic [3:0] INC;

    logic [3:0]  qn_d, qn_s, qn_p;
    logic        vld_d, vld_s, vld_p;
    logic [15:0] cnt_d, cnt_p;
    logic [3:0]  cnt_s;
    logic        sat_d, sat_s, sat_p;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q [$];
    obs_t got, want;

    always #5 CLK = ~CLK;

    oai_reg_toggle u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .INA(INA), .INB(INB), .INC(INC), .CLR(CLR),
        .QN(qn_d), .QVLD(vld_d), .TOGCNT(cnt_d), .TOGSAT(sat_d)
    );

    oai_reg_toggle #(.CNTW(4)) u_sat (
        .CLK(CLK), .RST(RST), .EN(EN), .INA(INA), .INB(INB), .INC(INC), .CLR(CLR),
        .QN(qn_s), .QVLD(vld_s), .TOGCNT(cnt_s), .TOGSAT(sat_s)
    );

    oai_reg_toggle #(.PIPE(2)) u_p2 (
        .CLK(CLK), .RST(RST), .EN(EN), .INA(INA), .INB(INB), .INC(INC), .CLR(CLR),
        .QN(qn_p), .QVLD(vld_p), .TOGCNT(cnt_p), .TOGSAT(sat_p)
    );

    // Gather one instance's outputs into a record.
    function automatic obs_t sample(input int which);
        obs_t o;
        case (which)
            1:       o = '{qn: qn_s, qvld: vld_s, cnt: {12'd0, cnt_s}, sat: sat_s};
            2:       o = '{qn: qn_p, qvld: vld_p, cnt: cnt_p, sat: sat_p};
            default: o = '{qn: qn_d, qvld: vld_d, cnt: cnt_d, sat: sat_d};
        endcase
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("qn=%h vld=%b cnt=%0d sat=%b", o.qn, o.qvld, o.cnt, o.sat);
    endfunction

    // Independent reference of the gate for the default shape.
    function automatic logic [3:0] ref_oai(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = !(c[i] && (a[i] || b[i]) && (a[i+4] || b[i+4]));
        end
        return r;
    endfunction

    function automatic obs_t mk(input logic [3:0] qn, input logic v,
                                input int cnt, input logic s);
        obs_t o;
        o = '{qn: qn, qvld: v, cnt: 16'(cnt), sat: s};
        return o;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int n = 0; n < 2; n++) begin
            EN  = 1'($urandom);
            CLR = 1'($urandom);
            INA = 8'($urandom);
            INB = 8'($urandom);
            INC = 4'($urandom);
            step();
        end
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back(mk(4'hF, 1'b0, 0, 1'b0));
            got  = sample(w);
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %s, want %s", w, fmt(got), fmt(want));
            end else begin
                $display("reset[%0d] %s ok", w, fmt(got));
            end
        end
        RST = 1'b0;
        CLR = 1'b0;
    endtask

    task automatic test_basic();
        INA = 8'h00; INB = 8'hFF; INC = 4'hA; EN = 1'b1;
        exp_q.push_back(mk(4'h5, 1'b1, 2, 1'b0));
        step();
        got  = sample(0);
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL basic: got %s, want %s", fmt(got), fmt(want));
        end else begin
            $display("basic %s ok", fmt(got));
        end
    endtask

    task automatic test_stall();
        EN = 1'b0; INC = 4'hF;
        for (int n = 0; n < 4; n++) begin
            if (n == 3) begin
                EN = 1'b1;
                exp_q.push_back(mk(4'h0, 1'b1, 4, 1'b0));
            end else begin
                exp_q.push_back(mk(4'h5, 1'b1, 2, 1'b0));
            end
            step();
            got  = sample(0);
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %s, want %s", n, fmt(got), fmt(want));
            end else begin
                $display("stall[%0d] %s ok", n, fmt(got));
            end
        end
    endtask

    // Random vectors with random stalls; QN and count follow a behavioural model.
    task automatic test_function();
        logic [3:0] qn_m = 4'h0;
        int         cnt_m = 4;
        logic [3:0] f;
        for (int n = 0; n < 16; n++) begin
            INA = 8'($urandom);
            INB = 8'($urandom);
            INC = 4'($urandom);
            EN  = ($urandom_range(0, 3) != 0);
            if (EN) begin
                f     = ref_oai(INA, INB, INC);
                cnt_m = cnt_m + $countones(f ^ qn_m);
                qn_m  = f;
            end
            exp_q.push_back(mk(qn_m, 1'b1, cnt_m, 1'b0));
            step();
            got  = sample(0);
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL func[%0d]: got %s, want %s", n, fmt(got), fmt(want));
            end else begin
                $display("func[%0d] en=%b %s ok", n, EN, fmt(got));
            end
        end
        // Leave QN at 0 with a known count for the clear test.
        INA = 8'hFF; INB = 8'hFF; INC = 4'hF; EN = 1'b1;
        exp_q.push_back(mk(4'h0, 1'b1, cnt_m + $countones(qn_m), 1'b0));
        step();
        got  = sample(0);
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL func_end: got %s, want %s", fmt(got), fmt(want));
        end else begin
            $display("func_end %s ok", fmt(got));
        end
    endtask

    // Clear collides with a 4-bit toggle, then counting resumes; clear also acts while stalled.
    task automatic test_clr();
        logic [3:0] inc_v [4];
        logic       clr_v [4];
        logic       en_v  [4];
        inc_v = '{4'h0, 4'hF, 4'h0, 4'hF};
        clr_v = '{1'b1, 1'b0, 1'b0, 1'b1};
        en_v  = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_q.push_back(mk(4'hF, 1'b1, 0, 1'b0));
        exp_q.push_back(mk(4'h0, 1'b1, 4, 1'b0));
        exp_q.push_back(mk(4'h0, 1'b1, 4, 1'b0));
        exp_q.push_back(mk(4'h0, 1'b1, 0, 1'b0));
        for (int n = 0; n < 4; n++) begin
            INC = inc_v[n]; CLR = clr_v[n]; EN = en_v[n];
            step();
            got  = sample(0);
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL clr[%0d]: got %s, want %s", n, fmt(got), fmt(want));
            end else begin
                $display("clr[%0d] %s ok", n, fmt(got));
            end
        end
        CLR = 1'b0;
    endtask

    // 4-bit counter: 4 toggles per edge saturates on the fourth edge and stays there.
    task automatic test_saturation();
        int   cnt_v [6];
        logic sat_v [6];
        cnt_v = '{4, 8, 12, 15, 15, 15};
        sat_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        RST = 1'b1; EN = 1'b1;
        step();
        RST = 1'b0;
        INA = 8'hFF; INB = 8'hFF;
        for (int n = 0; n < 6; n++) begin
            INC = (n % 2 == 0) ? 4'hF : 4'h0;
            exp_q.push_back(mk((n % 2 == 0) ? 4'h0 : 4'hF, 1'b1, cnt_v[n], sat_v[n]));
            step();
            got  = sample(1);
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL sat[%0d]: got %s, want %s", n, fmt(got), fmt(want));
            end else begin
                $display("sat[%0d] %s ok", n, fmt(got));
            end
        end
    endtask

    // Two-stage pipe: reset while stage 0 holds fresh data; QVLD waits two EN edges after.
    task automatic test_reset_mid();
        logic rst_v [6];
        logic en_v  [6];
        rst_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        en_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_q.push_back(mk(4'hF, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(4'hF, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(4'hF, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(4'hF, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(4'hF, 1'b0, 0, 1'b0));
        exp_q.push_back(mk(4'h5, 1'b1, 2, 1'b0));
        INA = 8'h00; INB = 8'hFF; INC = 4'hA; CLR = 1'b0;
        for (int n = 0; n < 6; n++) begin
            RST = rst_v[n]; EN = en_v[n];
            step();
            got  = sample(2);
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL rstmid[%0d]: got %s, want %s", n, fmt(got), fmt(want));
            end else begin
                $display("rstmid[%0d] %s ok", n, fmt(got));
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b0; EN = 1'b0; CLR = 1'b0;
        INA = 8'h00; INB = 8'h00; INC = 4'h0;
        test_reset();
        test_basic();
        test_stall();
        test_function();
        test_clr();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
